dp_ctrl_fsm: RTL and testbench

Instruction sequencer directly upstream of the 16-bit datapath. It accepts one 16-bit instruction per valid/ready handshake and decodes it into the datapath control bus: op, selectImm, Imm, readRegA, readRegB and loadReg. It steps a small FSM so that operands settle before writeback, and captures the datapath flags into a local processor status register (PSR).

---
 rtl/dp_ctrl_fsm.sv | 175 +++++++++++++++++
 tb/tb_dp_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ctrl_fsm.sv
// Instruction sequencer: latches one instruction per handshake and steps IDLE -> EXEC -> WRITE.
// Optional retire/illegal counters are built when DP_CTRL_PERF_EN is defined.
module dp_ctrl_fsm #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned FLAG_W  = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [7:0]         op,
  output logic               selectImm,
  output logic [7:0]         Imm,
  output logic [REG_AW-1:0]  readRegA,
  output logic [REG_AW-1:0]  readRegB,
  output logic [REG_AW-1:0]  loadReg,
`ifdef DP_CTRL_PERF_EN
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   illegal_cnt,
`endif
  input  logic [FLAG_W-1:0]  flags,
  output logic [FLAG_W-1:0]  psr,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {StIdle, StExec, StWrite} state_e;

  typedef struct packed {
    logic              legal;
    logic [7:0]        op;
    logic              sel;
    logic [7:0]        imm;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] wb;
  } dec_t;

  // Illegal encodings decode to all-zero controls with legal=0.
  function automatic dec_t decode(input logic [INSTR_W-1:0] w);
    dec_t       d;
    logic [3:0] hi, ext;
    d   = '0;
    hi  = w[15:12];
    ext = w[7:4];
    if ((hi == 4'h0 && ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hF}) ||
        (hi == 4'h8 && ext inside {4'h4, 4'h5, 4'hC, 4'hD})) begin
      d.legal = 1'b1;
      d.op    = {hi, ext};
      d.rb    = w[3:0];
    end else if (hi inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE}) begin
      d.legal = 1'b1;
      d.op    = {hi, 4'h0};
      d.sel   = 1'b1;
      d.imm   = w[7:0];
    end else if (hi == 4'h8 && w[7:5] == 3'b000) begin
      d.legal = 1'b1;
      d.op    = {4'h8, 3'b000, w[4]};
      d.sel   = 1'b1;
      d.imm   = {4'h0, w[3:0]};
    end
    if (d.legal) begin
      d.ra = w[11:8];
      d.wb = (d.op inside {8'h0B, 8'hB0, 8'hE0}) ? '0 : w[11:8];
    end
    return d;
  endfunction

  state_e              r_state;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_ready;
  logic [7:0]          r_op;
  logic                r_sel;
  logic [7:0]          r_imm;
  logic [REG_AW-1:0]   r_ra;
  logic [REG_AW-1:0]   r_rb;
  logic [REG_AW-1:0]   r_load;
  logic [FLAG_W-1:0]   r_psr;
  logic                r_done;
  logic                r_illegal;

  dec_t w_dec_in;
  dec_t w_dec_q;

  assign w_dec_in = decode(instr);
  assign w_dec_q  = decode(r_instr);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state   <= StIdle;
      r_instr   <= '0;
      r_ready   <= 1'b0;
      r_op      <= '0;
      r_sel     <= 1'b0;
      r_imm     <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_load    <= '0;
      r_psr     <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b1;
          // Accept only once instr_ready is visible, so nothing is taken on the release edge.
          if (r_ready && instr_valid) begin
            r_instr <= instr;
            r_ready <= 1'b0;
            r_state <= StExec;
            r_op    <= w_dec_in.op;
            r_sel   <= w_dec_in.sel;
            r_imm   <= w_dec_in.imm;
            r_ra    <= w_dec_in.ra;
            r_rb    <= w_dec_in.rb;
            r_load  <= '0;
          end
        end
        StExec: begin
          r_state   <= StWrite;
          r_load    <= w_dec_q.wb;
          r_done    <= w_dec_q.legal;
          r_illegal <= ~w_dec_q.legal;
        end
        StWrite: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_op    <= '0;
          r_sel   <= 1'b0;
          r_imm   <= '0;
          r_ra    <= '0;
          r_rb    <= '0;
          r_load  <= '0;
          if (r_done) r_psr <= flags;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef DP_CTRL_PERF_EN
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_illegal_cnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_retire_cnt  <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (r_done)    r_retire_cnt  <= r_retire_cnt + 1'b1;
      if (r_illegal) r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

  assign retire_cnt  = r_retire_cnt;
  assign illegal_cnt = r_illegal_cnt;
`endif

  assign instr_ready = r_ready;
  assign op          = r_op;
  assign selectImm   = r_sel;
  assign Imm         = r_imm;
  assign readRegA    = r_ra;
  assign readRegB    = r_rb;
  assign loadReg     = r_load;
  assign psr         = r_psr;
  assign done        = r_done;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_dp_ctrl_fsm.sv
// Testbench for dp_ctrl_fsm: directed vector table, handshake/reset sequences, and random
// instructions checked against a field-rule decode model.
module tb_dp_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [4:0]  flags = '0;
  logic        instr_ready, selectImm, done, illegal;
  logic [7:0]  op, Imm;
  logic [3:0]  readRegA, readRegB, loadReg;
  logic [4:0]  psr;
`ifdef DP_CTRL_PERF_EN
  logic [15:0] retire_cnt, illegal_cnt;
  int unsigned exp_ret = 0;
  int unsigned exp_ill = 0;
`endif

  dp_ctrl_fsm dut (
    .CLK(CLK), .CLR(CLR), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .op(op), .selectImm(selectImm), .Imm(Imm),
    .readRegA(readRegA), .readRegB(readRegB), .loadReg(loadReg),
`ifdef DP_CTRL_PERF_EN
    .retire_cnt(retire_cnt), .illegal_cnt(illegal_cnt),
`endif
    .flags(flags), .psr(psr), .done(done), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       legal;
    logic [7:0] op;
    logic       sel;
    logic [7:0] imm;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] wb;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    logic [4:0]  f;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_psr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit member(input int v, input int set[]);
    foreach (set[i]) if (set[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Reference decode built straight from the field rules with integer arithmetic.
  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int hi, rd, ext, rs, opv;
    int r0[] = '{1, 2, 3, 4, 5, 6, 7, 9, 11, 15};
    int r8[] = '{4, 5, 12, 13};
    int im[] = '{5, 6, 7, 9, 10, 11, 14};
    e   = '{default: 0};
    hi  = int'(w) / 4096;
    rd  = (int'(w) / 256) % 16;
    ext = (int'(w) / 16) % 16;
    rs  = int'(w) % 16;
    if ((hi == 0 && member(ext, r0)) || (hi == 8 && member(ext, r8))) begin
      e.legal = 1; opv = hi * 16 + ext; e.rb = 4'(rs);
    end else if (member(hi, im)) begin
      e.legal = 1; opv = hi * 16; e.sel = 1; e.imm = 8'(int'(w) % 256);
    end else if (hi == 8 && ext < 2) begin
      e.legal = 1; opv = 128 + ext; e.sel = 1; e.imm = 8'(rs);
    end else begin
      return e;
    end
    e.op = 8'(opv);
    e.ra = 4'(rd);
    e.wb = (opv == 'h0B || opv == 'hB0 || opv == 'hE0) ? 4'd0 : 4'(rd);
    return e;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, instr_ready, 1);
    chk({tag, " ctrl"}, {op, selectImm, Imm, readRegA, readRegB, loadReg, done, illegal}, 0);
    chk({tag, " psr"}, psr, exp_psr);
`ifdef DP_CTRL_PERF_EN
    chk({tag, " retire_cnt"}, retire_cnt, 32'(exp_ret[15:0]));
    chk({tag, " illegal_cnt"}, illegal_cnt, 32'(exp_ill[15:0]));
`endif
  endtask

  // Issues one instruction from IDLE and checks EXEC, WRITE and the return to IDLE.
  task automatic run_instr(input string tag, input logic [15:0] w, input logic [4:0] f,
                           input exp_t e);
    instr_valid = 1'b1;
    instr       = w;
    step();
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    flags       = f;
    chk({tag, " exec ready"}, instr_ready, 0);
    chk({tag, " exec op"}, op, e.op);
    chk({tag, " exec ctrl"}, {selectImm, Imm, readRegA, readRegB}, {e.sel, e.imm, e.ra, e.rb});
    chk({tag, " exec load/done/ill"}, {loadReg, done, illegal}, 0);
    step();
    chk({tag, " write ready"}, instr_ready, 0);
    chk({tag, " write ctrl"}, {op, selectImm, Imm, readRegA, readRegB},
        {e.op, e.sel, e.imm, e.ra, e.rb});
    chk({tag, " write loadReg"}, loadReg, e.wb);
    chk({tag, " write done/ill"}, {done, illegal}, {e.legal, ~e.legal});
    step();
    if (e.legal) exp_psr = f;
`ifdef DP_CTRL_PERF_EN
    if (e.legal) exp_ret++; else exp_ill++;
`endif
    chk_idle({tag, " idle"});
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{16'h5101, 5'h00, '{1, 8'h50, 1, 8'h01, 4'd1, 4'd0, 4'd1}};
    tbl[1]  = '{16'h0253, 5'h03, '{1, 8'h05, 0, 8'h00, 4'd2, 4'd3, 4'd2}};
    tbl[2]  = '{16'h04B5, 5'h04, '{1, 8'h0B, 0, 8'h00, 4'd4, 4'd5, 4'd0}};
    tbl[3]  = '{16'h8603, 5'h11, '{1, 8'h80, 1, 8'h03, 4'd6, 4'd0, 4'd6}};
    tbl[4]  = '{16'h8613, 5'h12, '{1, 8'h81, 1, 8'h03, 4'd6, 4'd0, 4'd6}};
    tbl[5]  = '{16'h86D7, 5'h13, '{1, 8'h8D, 0, 8'h00, 4'd6, 4'd7, 4'd6}};
    tbl[6]  = '{16'hC123, 5'h1F, '{0, 8'h00, 0, 8'h00, 4'd0, 4'd0, 4'd0}};
    tbl[7]  = '{16'hB2FF, 5'h08, '{1, 8'hB0, 1, 8'hFF, 4'd2, 4'd0, 4'd0}};
    tbl[8]  = '{16'hE345, 5'h09, '{1, 8'hE0, 1, 8'h45, 4'd3, 4'd0, 4'd0}};
    tbl[9]  = '{16'h0F00, 5'h0A, '{0, 8'h00, 0, 8'h00, 4'd0, 4'd0, 4'd0}};
    tbl[10] = '{16'h8620, 5'h0B, '{0, 8'h00, 0, 8'h00, 4'd0, 4'd0, 4'd0}};
    tbl[11] = '{16'h5000, 5'h0C, '{1, 8'h50, 1, 8'h00, 4'd0, 4'd0, 4'd0}};

    // Reset state
    #3;
    chk("reset ready", instr_ready, 0);
    chk("reset outputs", {op, selectImm, Imm, readRegA, readRegB, loadReg, psr, done, illegal}, 0);
    #5 CLR = 1'b1;
    step();
    chk_idle("post-reset");

    foreach (tbl[i]) run_instr($sformatf("vec%0d", i), tbl[i].w, tbl[i].f, tbl[i].e);

    // Held valid: accepts at N and N+3 only; instr changes mid-flight are ignored
    instr_valid = 1'b1;
    instr       = 16'h5101;
    flags       = 5'h15;
    step();
    chk("hold first exec op", op, 8'h50);
    instr = 16'h0253;
    step();
    chk("hold first write op", op, 8'h50);
    chk("hold first write loadReg", loadReg, 1);
    step();
    exp_psr = 5'h15;
`ifdef DP_CTRL_PERF_EN
    exp_ret++;
`endif
    chk("hold idle ready", instr_ready, 1);
    chk("hold idle op", op, 0);
    flags = 5'h06;
    step();
    instr_valid = 1'b0;
    chk("hold second exec op", op, 8'h05);
    chk("hold second exec regs", {readRegA, readRegB}, {4'd2, 4'd3});
    step();
    chk("hold second write loadReg", loadReg, 2);
    step();
    exp_psr = 5'h06;
`ifdef DP_CTRL_PERF_EN
    exp_ret++;
`endif
    chk_idle("hold idle2");

    // Reset during EXEC drops the instruction
    instr_valid = 1'b1;
    instr       = 16'h5707;
    step();
    instr_valid = 1'b0;
    chk("abort exec op", op, 8'h50);
    #2 CLR = 1'b0;
    #1;
    chk("abort async clear", {instr_ready, op, selectImm, Imm, readRegA, readRegB, loadReg, psr,
                              done, illegal}, 0);
    step();
    chk("abort held ready", instr_ready, 0);
    chk("abort held loadReg", loadReg, 0);
    #3 CLR = 1'b1;
    exp_psr = '0;
`ifdef DP_CTRL_PERF_EN
    exp_ret = 0;
    exp_ill = 0;
`endif
    step();
    chk_idle("abort release");
    step();
    chk("abort no late write", {loadReg, done, illegal}, 0);

    // Random instructions against the model, with random idle gaps
    for (int n = 0; n < 200; n++) begin
      logic [15:0] w;
      logic [4:0]  f;
      w = 16'($urandom);
      if (n % 4 == 0) w[15:12] = ($urandom_range(0, 1) == 1) ? 4'h8 : 4'h0;
      f = 5'($urandom);
      run_instr($sformatf("rnd%0d w=%04h", n, w), w, f, model(w));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
